// File: rtl/rv32i_pkg.sv
// Shared RV32I control definitions: FSM state encoding, mux selects, trap causes,
// opcode constants and the one-hot opcode-class flag bundle from rv32i_decode.
package rv32i_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 5;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
  localparam logic [1:0] TRAP_FETCH_TO = 2'd2;
  localparam logic [1:0] TRAP_MEM_TO   = 2'd3;

  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;

  typedef struct packed {
    logic branch;
    logic r_alu;
    logic jalr;
    logic jal;
    logic lui;
    logic auipc;
    logic i_alu;
    logic load;
    logic store;
    logic fence;
  } op_flags_t;

  // A legal instruction raises exactly one opcode-class flag.
  function automatic logic is_one_hot(input op_flags_t f);
    return $countones(f) == 1;
  endfunction

endpackage

// File: rtl/rv32i_wait_timer.sv
// Wait-cycle counter for memory handshakes; flags expiry on the last permitted cycle.
module rv32i_wait_timer #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clock) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // Clear wins so that a state change always restarts the wait window.
  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + CNT_W'(1);
  end

  assign expired_o = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle sequencer for the minimum RV32I core: fetch/decode/execute/memory/writeback
// strobes decoded from the current state, plus sticky trap on illegal opcode or timeout.
module rv32i_control_fsm
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       instr_ready,
  input  logic       branch_type,
  input  logic       register_type_alu,
  input  logic       integer_type_jump,
  input  logic       jump_type,
  input  logic       unconditional_type_load,
  input  logic       unconditional_type_add,
  input  logic       integer_type_alu,
  input  logic       integer_type_load,
  input  logic       store_type,
  input  logic       fence_type,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       instr_req,
  output logic       ir_load,
  output logic       alu_src_a_pc,
  output logic       alu_src_b_imm,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  op_flags_t  flags;
  state_e     state_q, state_d;
  logic       is_store_q, is_store_d;
  logic       trap_q, trap_d;
  logic [1:0] cause_q, cause_d;
  logic       tmr_clear, tmr_en, tmr_expired;
  logic       legal, a_pc_sel, b_imm_sel;

  assign flags = {branch_type, register_type_alu, integer_type_jump, jump_type,
                  unconditional_type_load, unconditional_type_add, integer_type_alu,
                  integer_type_load, store_type, fence_type};

  assign legal     = is_one_hot(flags);
  assign a_pc_sel  = flags.auipc | flags.branch | flags.jal;
  assign b_imm_sel = flags.i_alu | flags.auipc | flags.load | flags.store |
                     flags.branch | flags.jal | flags.jalr;

  rv32i_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (tmr_clear),
    .enable_i  (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_FETCH;
      is_store_q <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= TRAP_NONE;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_store_d    = is_store_q;
    trap_d        = trap_q;
    cause_d       = cause_q;
    tmr_en        = 1'b0;
    instr_req     = 1'b0;
    ir_load       = 1'b0;
    alu_src_a_pc  = 1'b0;
    alu_src_b_imm = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_SEL_ALU;
    pc_write      = 1'b0;
    pc_sel        = PC_SEL_PLUS4;
    retire        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = TRAP_FETCH_TO;
          end
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        is_store_d = flags.store;
        if (!legal) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = TRAP_ILLEGAL;
        end else begin
          alu_src_a_pc  = a_pc_sel;
          alu_src_b_imm = b_imm_sel;
          if (flags.load || flags.store) begin
            state_d = ST_MEMORY;
          end else if (flags.branch || flags.fence) begin
            pc_write = 1'b1;
            pc_sel   = (flags.branch && branch_taken) ? PC_SEL_BRANCH : PC_SEL_PLUS4;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end else if (flags.jal || flags.jalr) begin
            reg_write = 1'b1;
            wb_sel    = WB_SEL_PC4;
            pc_write  = 1'b1;
            pc_sel    = flags.jalr ? PC_SEL_JALR : PC_SEL_BRANCH;
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_MEMORY: begin
        mem_req       = 1'b1;
        mem_we        = is_store_q;
        alu_src_b_imm = 1'b1;
        if (mem_ready) begin
          if (is_store_q) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = TRAP_MEM_TO;
          end
        end
      end
      ST_WRITEBACK: begin
        alu_src_a_pc  = a_pc_sel;
        alu_src_b_imm = b_imm_sel;
        reg_write     = 1'b1;
        wb_sel        = flags.load ? WB_SEL_MEM : (flags.lui ? WB_SEL_IMM : WB_SEL_ALU);
        pc_write      = 1'b1;
        retire        = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    tmr_clear = (state_d != state_q);

    // Everything reads as idle while reset is held.
    if (!reset_n) begin
      instr_req     = 1'b0;
      ir_load       = 1'b0;
      alu_src_a_pc  = 1'b0;
      alu_src_b_imm = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = WB_SEL_ALU;
      pc_write      = 1'b0;
      pc_sel        = PC_SEL_PLUS4;
      retire        = 1'b0;
    end
  end

  assign trap       = trap_q & reset_n;
  assign trap_cause = reset_n ? cause_q : TRAP_NONE;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Randomized bench: each instruction is expanded into its expected per-cycle strobe trace.
module tb_rv32i_control_fsm;

  localparam int TO = 16;
  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_LOAD = 4, K_STORE = 5;
  localparam int K_BR = 6, K_JAL = 7, K_JALR = 8, K_FENCE = 9, K_ILL0 = 10, K_ILL2 = 11;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic instr_ready = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;
  logic branch_type = 1'b0, register_type_alu = 1'b0, integer_type_jump = 1'b0, jump_type = 1'b0;
  logic unconditional_type_load = 1'b0, unconditional_type_add = 1'b0, integer_type_alu = 1'b0;
  logic integer_type_load = 1'b0, store_type = 1'b0, fence_type = 1'b0;
  logic instr_req, ir_load, alu_src_a_pc, alu_src_b_imm, mem_req, mem_we, reg_write;
  logic pc_write, retire, trap;
  logic [1:0] wb_sel, pc_sel, trap_cause;
  logic [15:0] obs;

  always #5 clock = ~clock;

  rv32i_control_fsm dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .instr_ready             (instr_ready),
    .branch_type             (branch_type),
    .register_type_alu       (register_type_alu),
    .integer_type_jump       (integer_type_jump),
    .jump_type               (jump_type),
    .unconditional_type_load (unconditional_type_load),
    .unconditional_type_add  (unconditional_type_add),
    .integer_type_alu        (integer_type_alu),
    .integer_type_load       (integer_type_load),
    .store_type              (store_type),
    .fence_type              (fence_type),
    .branch_taken            (branch_taken),
    .mem_ready               (mem_ready),
    .instr_req               (instr_req),
    .ir_load                 (ir_load),
    .alu_src_a_pc            (alu_src_a_pc),
    .alu_src_b_imm           (alu_src_b_imm),
    .mem_req                 (mem_req),
    .mem_we                  (mem_we),
    .reg_write               (reg_write),
    .wb_sel                  (wb_sel),
    .pc_write                (pc_write),
    .pc_sel                  (pc_sel),
    .retire                  (retire),
    .trap                    (trap),
    .trap_cause              (trap_cause)
  );

  assign obs = {instr_req, ir_load, alu_src_a_pc, alu_src_b_imm, mem_req, mem_we, reg_write,
                wb_sel, pc_write, pc_sel, retire, trap, trap_cause};

  typedef struct {
    logic        rdy;
    logic [9:0]  fl;
    logic        tk;
    logic        mr;
    logic [15:0] exp;
  } cyc_t;

  cyc_t  cq[$];
  string tq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    need_rst = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (req,irl,apc,bimm,mreq,mwe,rw,wb2,pcw,pcs2,ret,trap,cause2)",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic ireq, input logic irl, input logic apc,
                                     input logic bimm, input logic mreq, input logic mwe,
                                     input logic rw, input logic [1:0] wb, input logic pcw,
                                     input logic [1:0] pcs, input logic ret, input logic tr,
                                     input logic [1:0] cs);
    return {ireq, irl, apc, bimm, mreq, mwe, rw, wb, pcw, pcs, ret, tr, cs};
  endfunction

  // Flag order: branch, R-alu, jalr, jal, lui, auipc, I-alu, load, store, fence.
  function automatic logic [9:0] flags_for(input int kind);
    logic [9:0] one;
    int i, j;
    one = 10'd1;
    case (kind)
      K_R:     return one << 8;
      K_I:     return one << 3;
      K_LUI:   return one << 5;
      K_AUIPC: return one << 4;
      K_LOAD:  return one << 2;
      K_STORE: return one << 1;
      K_BR:    return one << 9;
      K_JAL:   return one << 6;
      K_JALR:  return one << 7;
      K_FENCE: return one;
      K_ILL2: begin
        i = int'($urandom_range(0, 9));
        j = (i + 1 + int'($urandom_range(0, 8))) % 10;
        return (one << i) | (one << j);
      end
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic rdy, input logic [9:0] fl, input logic tk, input logic mr,
                      input logic [15:0] exp, input string tag);
    cyc_t c;
    c.rdy = rdy; c.fl = fl; c.tk = tk; c.mr = mr; c.exp = exp;
    cq.push_back(c);
    tq.push_back(tag);
  endtask

  task automatic add_trap(input logic [1:0] cs, input int id);
    for (int i = 0; i < 4; i++)
      push(rb(), 10'($urandom), rb(), rb(), pk(0,0,0,0,0,0,0,2'd0,0,2'd0,0,1,cs),
           $sformatf("i%0d.trap", id));
    need_rst = 1'b1;
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic plan(input int kind, input int fw, input int mw, input logic tk, input int id);
    logic [9:0] f;
    logic apc, bimm, st;
    logic [1:0] wb;
    f    = flags_for(kind);
    apc  = (kind == K_AUIPC) || (kind == K_BR) || (kind == K_JAL);
    bimm = (kind == K_I) || (kind == K_AUIPC) || (kind == K_LOAD) || (kind == K_STORE) ||
           (kind == K_BR) || (kind == K_JAL) || (kind == K_JALR);
    st   = (kind == K_STORE);
    wb   = (kind == K_LOAD) ? 2'd1 : ((kind == K_LUI) ? 2'd3 : 2'd0);
    for (int i = 0; i < fw && i < TO; i++)
      push(1'b0, 10'($urandom), rb(), rb(), pk(1,0,0,0,0,0,0,2'd0,0,2'd0,0,0,2'd0),
           $sformatf("i%0d.fetch_wait%0d", id, i));
    if (fw >= TO) begin
      add_trap(2'd2, id);
      return;
    end
    push(1'b1, 10'($urandom), rb(), rb(), pk(1,1,0,0,0,0,0,2'd0,0,2'd0,0,0,2'd0),
         $sformatf("i%0d.fetch", id));
    push(rb(), 10'($urandom), rb(), rb(), 16'h0, $sformatf("i%0d.decode", id));
    case (kind)
      K_ILL0, K_ILL2: begin
        push(rb(), f, rb(), rb(), 16'h0, $sformatf("i%0d.exec_illegal", id));
        add_trap(2'd1, id);
        return;
      end
      K_BR: begin
        push(rb(), f, tk, rb(), pk(0,0,1,1,0,0,0,2'd0,1,tk ? 2'd1 : 2'd0,1,0,2'd0),
             $sformatf("i%0d.exec_branch", id));
        return;
      end
      K_FENCE: begin
        push(rb(), f, rb(), rb(), pk(0,0,0,0,0,0,0,2'd0,1,2'd0,1,0,2'd0),
             $sformatf("i%0d.exec_fence", id));
        return;
      end
      K_JAL, K_JALR: begin
        push(rb(), f, rb(), rb(),
             pk(0,0,apc,1,0,0,1,2'd2,1,(kind == K_JALR) ? 2'd2 : 2'd1,1,0,2'd0),
             $sformatf("i%0d.exec_jump", id));
        return;
      end
      default:
        push(rb(), f, rb(), rb(), pk(0,0,apc,bimm,0,0,0,2'd0,0,2'd0,0,0,2'd0),
             $sformatf("i%0d.exec", id));
    endcase
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int i = 0; i < mw && i < TO; i++)
        push(rb(), f, rb(), 1'b0, pk(0,0,0,1,1,st,0,2'd0,0,2'd0,0,0,2'd0),
             $sformatf("i%0d.mem_wait%0d", id, i));
      if (mw >= TO) begin
        add_trap(2'd3, id);
        return;
      end
      push(rb(), f, rb(), 1'b1, pk(0,0,0,1,1,st,0,2'd0,st,2'd0,st,0,2'd0),
           $sformatf("i%0d.mem_done", id));
      if (st) return;
    end
    push(rb(), f, rb(), rb(), pk(0,0,apc,bimm,0,0,1,wb,1,2'd0,1,0,2'd0),
         $sformatf("i%0d.writeback", id));
  endtask

  task automatic step(input logic rst, input logic rdy, input logic [9:0] fl, input logic tk,
                      input logic mr, input logic [15:0] exp, input string tag);
    @(posedge clock);
    #1;
    reset_n      = rst;
    instr_ready  = rdy;
    {branch_type, register_type_alu, integer_type_jump, jump_type, unconditional_type_load,
     unconditional_type_add, integer_type_alu, integer_type_load, store_type, fence_type} = fl;
    branch_taken = tk;
    mem_ready    = mr;
    @(negedge clock);
    check(tag, obs, exp);
  endtask

  task automatic do_reset();
    step(1'b0, rb(), 10'($urandom), rb(), rb(), 16'h0, "reset");
  endtask

  // Play the planned trace; a nonzero cut aborts after that many cycles with a reset.
  task automatic run(input int cut);
    int n;
    cyc_t c;
    n = 0;
    while (cq.size() > 0) begin
      if (cut > 0 && n == cut) break;
      c = cq.pop_front();
      step(1'b1, c.rdy, c.fl, c.tk, c.mr, c.exp, tq.pop_front());
      n++;
    end
    cq.delete();
    tq.delete();
    if (need_rst || (cut > 0 && n == cut)) begin
      do_reset();
      need_rst = 1'b0;
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 31));
    if (r == 0) return 16;
    if (r == 1) return 15;
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    int kind, fw, mw, cut, len;
    do_reset();
    do_reset();
    plan(K_I, 0, 0, 1'b0, 0);      run(0);
    plan(K_BR, 0, 0, 1'b1, 1);     run(0);
    plan(K_BR, 0, 0, 1'b0, 2);     run(0);
    plan(K_LOAD, 0, 4, 1'b0, 3);   run(0);
    plan(K_STORE, 1, 2, 1'b0, 4);  run(0);
    plan(K_ILL0, 0, 0, 1'b0, 5);   run(0);
    plan(K_ILL2, 2, 0, 1'b0, 6);   run(0);
    plan(K_R, 16, 0, 1'b0, 7);     run(0);
    plan(K_LOAD, 0, 16, 1'b0, 8);  run(0);
    plan(K_STORE, 15, 15, 1'b0, 9); run(0);
    plan(K_LUI, 0, 0, 1'b0, 10);   run(0);
    plan(K_JALR, 0, 0, 1'b0, 11);  run(0);
    plan(K_LOAD, 0, 6, 1'b0, 12);  run(5);
    plan(K_AUIPC, 0, 0, 1'b0, 13); run(0);
    for (int id = 100; id < 500; id++) begin
      kind = ($urandom_range(0, 15) == 0) ? int'($urandom_range(K_ILL0, K_ILL2))
                                          : int'($urandom_range(K_R, K_FENCE));
      fw = pick_wait();
      mw = pick_wait();
      plan(kind, fw, mw, rb(), id);
      len = cq.size();
      cut = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, len)) : 0;
      run(cut);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
